// File: rtl/count_arbiter_pkg.sv
// Shared defaults and helpers for the count arbiter: requester count, queue depth,
// display counter width, and pointer sizing.
package count_arbiter_pkg;

  localparam int NREQ_DEF    = 3;
  localparam int PEND_W_DEF  = 4;
  localparam int COUNT_W_DEF = 16;

  // Pointer width for n requesters; never narrower than one bit.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/count_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set bit of vec at or after ptr
// (wrapping), as both a one-hot vector and a binary index.
module count_arbiter_rr_pick #(
  parameter int NREQ  = 3,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  vec,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  onehot,
  output logic [PTR_W-1:0] idx
);

  logic found;
  int   j;

  always_comb begin
    // NOTE: every output and temporary gets a default before the search loop, so no
    // path through this block leaves a value unassigned and no latch is inferred.
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    j      = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!found && vec[j]) begin
        found     = 1'b1;
        onehot[j] = 1'b1;
        idx       = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/count_arbiter.sv
// Shared event counter fed by NREQ pulse sources through saturating pending queues,
// drained one count per clock by a round-robin arbiter.
module count_arbiter
  import count_arbiter_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int PEND_W  = PEND_W_DEF,
  parameter int COUNT_W = COUNT_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic               run,
  input  logic               clr,
  input  logic               clr_ovf,
  output logic [NREQ-1:0]    grant,
  output logic [COUNT_W-1:0] count,
  output logic               busy,
  output logic [NREQ-1:0]    overflow
);

  localparam int PTR_W = ptr_w(NREQ);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [NREQ-1:0][PEND_W-1:0] pend;
  logic [NREQ-1:0]             nz;
  logic [NREQ-1:0]             pick;
  logic [NREQ-1:0]             ovf_set;
  logic [PTR_W-1:0]            ptr;
  logic [PTR_W-1:0]            pick_idx;

  generate
    for (genvar i = 0; i < NREQ; i++) begin : g_req
      assign nz[i]      = |pend[i];
      // A full queue loses the event only when it is not being drained this cycle.
      assign ovf_set[i] = !clr && req[i] && !grant[i] && (pend[i] == PEND_MAX);
    end
  endgenerate

  count_arbiter_rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .vec    (nz),
    .ptr    (ptr),
    .onehot (pick),
    .idx    (pick_idx)
  );

  // Grant depends only on registered queues/pointer and run, never on req.
  assign grant = run ? pick : '0;
  assign busy  = |nz;

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    if (!reset) begin
      pend  <= '0;
      ptr   <= '0;
      count <= '0;
    end else if (clr) begin
      pend  <= '0;
      ptr   <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && !grant[i]) begin
          if (pend[i] != PEND_MAX) pend[i] <= pend[i] + 1'b1;
        end else if (!req[i] && grant[i]) begin
          pend[i] <= pend[i] - 1'b1;
        end
      end
      if (|grant) begin
        count <= count + 1'b1;
        ptr   <= (pick_idx == PTR_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
      end
    end
  end

  // Sticky flags; a bit being set wins over a simultaneous clear request.
  always_ff @(posedge clock) begin
    if (!reset) overflow <= '0;
    else        overflow <= (clr_ovf ? '0 : overflow) | ovf_set;
  end

endmodule
